// File: rtl/brick_eraser.sv
// brick_eraser
// Takes brick-hit pulses from the ball controller and queues the struck brick
// origins. Each queued brick is erased by streaming background-colour pixel
// writes, one per cycle in row-major order. The block also keeps a saturating
// score of accepted hits.
//
// Ports
//   i_clk          system clock, all state on posedge
//   i_reset        asynchronous active-high reset
//   i_brick_hit    one-cycle hit pulse, qualifies i_brick_x / i_brick_y
//   i_brick_x      struck brick origin x (9 bits)
//   i_brick_y      struck brick origin y (8 bits)
//   o_plot         pixel write enable to the VGA adapter
//   o_plot_x       pixel x
//   o_plot_y       pixel y
//   o_plot_colour  pixel colour, always BG_COLOUR
//   o_busy         erasing, or hits still queued
//   o_score        accepted hits, saturating
//   o_overflow     sticky: a hit was dropped because the queue was full
//
// States
//   S_IDLE | no brick being erased; pops the queue head when one is present
//   S_DRAW | o_plot_x/o_plot_y hold pixel (r_cx, r_cy) of the current brick

module brick_eraser #(
    parameter int          BRICK_W    = 32,
    parameter int          BRICK_H    = 4,
    parameter logic [2:0]  BG_COLOUR  = 3'b000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          SCORE_W    = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_brick_hit,
    input  logic [8:0]         i_brick_x,
    input  logic [7:0]         i_brick_y,
    output logic               o_plot,
    output logic [8:0]         o_plot_x,
    output logic [7:0]         o_plot_y,
    output logic [2:0]         o_plot_colour,
    output logic               o_busy,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_overflow
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CXW = $clog2(BRICK_W + 1);
    localparam int CYW = $clog2(BRICK_H + 1);
    localparam logic [CXW-1:0] CX_LAST = CXW'(BRICK_W);
    localparam logic [CYW-1:0] CY_LAST = CYW'(BRICK_H);

    typedef enum logic {S_IDLE, S_DRAW} state_t;

    state_t              r_state;
    state_t              w_state_n;

    logic [16:0]         r_mem [FIFO_DEPTH];
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic [AW:0]         w_wr_ptr_n;
    logic [AW:0]         w_rd_ptr_n;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [16:0]         w_head;

    logic [8:0]          r_base_x;
    logic [7:0]          r_base_y;
    logic [CXW-1:0]      r_cx;
    logic [CYW-1:0]      r_cy;
    logic [8:0]          w_base_x_n;
    logic [7:0]          w_base_y_n;
    logic [CXW-1:0]      w_cx_n;
    logic [CYW-1:0]      w_cy_n;

    logic                r_plot;
    logic [8:0]          r_plot_x;
    logic [7:0]          r_plot_y;
    logic                r_busy;
    logic [SCORE_W-1:0]  r_score;
    logic                r_overflow;
    logic                w_plot_n;
    logic [8:0]          w_plot_x_n;
    logic [7:0]          w_plot_y_n;
    logic                w_busy_n;
    logic                w_last_pixel;

    // Full/empty from pointers carrying an extra wrap bit.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    // A full queue still accepts a hit when the head is popped on the same edge.
    assign w_push     = i_brick_hit && (!w_full || w_pop);
    assign w_wr_ptr_n = r_wr_ptr + (AW+1)'(w_push);
    assign w_rd_ptr_n = r_rd_ptr + (AW+1)'(w_pop);

    assign w_last_pixel = (r_cx == CX_LAST) && (r_cy == CY_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_pop      = 1'b0;
        w_base_x_n = r_base_x;
        w_base_y_n = r_base_y;
        w_cx_n     = r_cx;
        w_cy_n     = r_cy;
        w_plot_n   = 1'b0;
        w_plot_x_n = r_plot_x;
        w_plot_y_n = r_plot_y;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_base_x_n = w_head[16:8];
                    w_base_y_n = w_head[7:0];
                    w_cx_n     = '0;
                    w_cy_n     = '0;
                    w_state_n  = S_DRAW;
                end
            end
            S_DRAW: begin
                if (w_last_pixel) begin
                    w_cx_n = '0;
                    w_cy_n = '0;
                    if (!w_empty) begin
                        // Back-to-back bricks: the next one starts with no gap cycle.
                        w_pop      = 1'b1;
                        w_base_x_n = w_head[16:8];
                        w_base_y_n = w_head[7:0];
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end else if (r_cx == CX_LAST) begin
                    w_cx_n = '0;
                    w_cy_n = r_cy + CYW'(1);
                end else begin
                    w_cx_n = r_cx + CXW'(1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // The output registers show the pixel selected by the next counter values.
        // Coordinates wrap modulo 512/256; off-screen pixels keep their cycle.
        if (w_state_n == S_DRAW) begin
            w_plot_x_n = w_base_x_n + 9'(w_cx_n);
            w_plot_y_n = w_base_y_n + 8'(w_cy_n);
            w_plot_n   = (w_plot_x_n < 9'd320) && (w_plot_y_n < 8'd240);
        end

        w_busy_n = (w_state_n == S_DRAW) || (w_wr_ptr_n != w_rd_ptr_n);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_base_x   <= '0;
            r_base_y   <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_plot     <= 1'b0;
            r_plot_x   <= '0;
            r_plot_y   <= '0;
            r_busy     <= 1'b0;
            r_score    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {i_brick_x, i_brick_y};
                if (r_score != {SCORE_W{1'b1}}) begin
                    r_score <= r_score + SCORE_W'(1);
                end
            end
            if (i_brick_hit && !w_push) begin
                r_overflow <= 1'b1;
            end
            r_wr_ptr <= w_wr_ptr_n;
            r_rd_ptr <= w_rd_ptr_n;
            r_base_x <= w_base_x_n;
            r_base_y <= w_base_y_n;
            r_cx     <= w_cx_n;
            r_cy     <= w_cy_n;
            r_plot   <= w_plot_n;
            r_plot_x <= w_plot_x_n;
            r_plot_y <= w_plot_y_n;
            r_busy   <= w_busy_n;
        end
    end

    assign o_plot        = r_plot;
    assign o_plot_x      = r_plot_x;
    assign o_plot_y      = r_plot_y;
    assign o_plot_colour = BG_COLOUR;
    assign o_busy        = r_busy;
    assign o_score       = r_score;
    assign o_overflow    = r_overflow;

endmodule

// File: doc/brick_eraser.md
Name: brick_eraser

Overview:
Consumer end of the ball controller's brick-hit interface. Accepts `brick_hit` pulses carrying the struck brick's origin and queues them. Erases each brick from the frame buffer by streaming background-colour pixel writes to the VGA adapter's plot port, and keeps the running score. Sits between ball control and the VGA adapter write mux.

Parameters:
BRICK_W, 32, brick extent in x; erased columns are brick_x .. brick_x+BRICK_W inclusive (matches collision box).
BRICK_H, 4, brick extent in y; erased rows are brick_y .. brick_y+BRICK_H inclusive.
BG_COLOUR, 3'b000, colour written to every erased pixel.
FIFO_DEPTH, 4, hit queue entries; power of two, >=2.
SCORE_W, 8, score counter width.

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
brick_hit  in  1  one-cycle pulse; brick_x/brick_y valid in the same cycle
brick_x  in  9  struck brick origin x
brick_y  in  8  struck brick origin y
plot  out  1  pixel write enable to VGA adapter
plot_x  out  9  pixel x
plot_y  out  8  pixel y
plot_colour  out  3  pixel colour, always BG_COLOUR
busy  out  1  high while erasing or queue non-empty
score  out  SCORE_W  accepted hits, saturating
overflow  out  1  sticky: a hit was dropped because the queue was full

Behaviour:
- Reset, asynchronous: plot=0, plot_x=0, plot_y=0, busy=0, score=0, overflow=0, queue empty, FSM=IDLE, column/row counters=0. Any erase in progress is abandoned; queued hits are lost.
- Queue: FIFO of {brick_x, brick_y}, FIFO_DEPTH entries, registered read/write pointers with an extra wrap bit.
  - Push on a clk edge with brick_hit=1.
  - If full and no pop occurs that edge, the hit is dropped: overflow<=1 (sticky until reset) and score is unchanged.
  - Push and pop on the same edge while full: both happen and the hit is accepted.
- Score: +1 on every accepted push. Saturates at all-ones and does not wrap.
- FSM has two states, IDLE and DRAW.
  - IDLE: if the queue is non-empty, pop the head into base_x/base_y, set cx=0, cy=0, go to DRAW.
  - DRAW: one pixel per cycle, row-major. cx counts 0..BRICK_W; at cx=BRICK_W, cx<=0 and cy++.
  - On the last pixel (cx=BRICK_W, cy=BRICK_H): if the queue is non-empty, pop the next head and restart at cx=cy=0 with no gap cycle; otherwise go to IDLE.
- Outputs are registered:
  - plot_x = base_x+cx and plot_y = base_y+cy, computed at 9/8 bits and truncated (modulo 512/256).
  - plot=1 in DRAW only when plot_x<320 and plot_y<240. An off-screen pixel still consumes its cycle with plot=0.
- Pixels per brick: (BRICK_W+1)*(BRICK_H+1) = 165 at defaults.
- Latency: brick_hit sampled at edge t, queue non-empty after t. FSM enters DRAW at edge t+1. First plot=1 cycle follows edge t+1, i.e. the second cycle after the pulse. Total span for one brick is 165 cycles.
- busy = (state==DRAW) | queue non-empty; it is registered in step with plot. busy falls on the cycle after the last pixel when nothing is queued.
- The same brick origin hit twice is erased twice and scored twice; no de-duplication is performed.
- The block never back-pressures ball control. Dropping on a full queue is the only loss mechanism.

Test Plan:
1. Reset, then a single pulse with brick_x=100, brick_y=60: first plot two cycles after the pulse at (100,60). Exactly 165 plot pulses with last at (132,64), all colour 0. score=1, busy low afterwards.
2. Pulses at (100,60), then (150,60) 10 cycles later, then (200,60): three contiguous 165-cycle bursts with no gap, 495 plots in total. score=3, overflow=0.
3. Five pulses on consecutive cycles while idle (DEPTH=4): the first is popped at once, the remaining four fill the queue, and none are dropped. Six pulses: the sixth is dropped, overflow=1, score=5, and exactly 5 bricks are erased.
4. Pulse with brick_x=300, brick_y=238: only pixels with x<=319 and y<=239 get plot=1 (20 cols × 2 rows = 40). Duration is still 165 cycles.
5. Assert reset asynchronously mid-erase, after 50 pixels with one hit queued: plot drops without waiting for a clk edge. score=0, busy=0. After release no further plots occur until a new pulse arrives.
6. Force score to 255 (SCORE_W=8), then pulse: score stays 255 and the brick is still erased.
